// File: rtl/avalon_accel.sv
// XTEA block-encryption accelerator: Avalon-MM slave for setup, Avalon-MM master
// that streams 64-bit blocks from SRC, encrypts them and writes them to DEST.
module avalon_accel #(
   parameter logic [31:0] DELTA  = 32'h9E3779B9,
   parameter int          ROUNDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        irq
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, WR0, WR1, NEXT} state_t;

   localparam logic [31:0] LAST_ROUND = 32'(ROUNDS - 1);

   state_t      state;
   logic [31:0] key [4];
   logic [31:0] src_reg, dest_reg, num_reg;
   logic [31:0] src_cnt, dest_cnt, rem_cnt;
   logic [31:0] v0, v1, sum, round_cnt;
   logic [31:0] v0_n, v1_n, sum_n;
   logic        busy, ctrl_wr, cfg_wr;
   logic        addr_unused;

   // Byte lanes inside a register are not decoded.
   assign addr_unused = &{1'b0, avs_address[1:0]};

   assign busy    = (state != IDLE);
   assign ctrl_wr = avs_write && (avs_address[4:2] == 3'd7);
   assign cfg_wr  = avs_write && !busy && (avs_address[4:2] != 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) key[i] <= '0;
         src_reg  <= '0;
         dest_reg <= '0;
         num_reg  <= '0;
      end else if (cfg_wr) begin
         case (avs_address[4:2])
            3'd4:    src_reg  <= avs_writedata;
            3'd5:    dest_reg <= avs_writedata;
            3'd6:    num_reg  <= avs_writedata;
            default: key[avs_address[3:2]] <= avs_writedata;
         endcase
      end
   end

   always_comb begin
      case (avs_address[4:2])
         3'd4:    avs_readdata = src_reg;
         3'd5:    avs_readdata = dest_reg;
         3'd6:    avs_readdata = num_reg;
         3'd7:    avs_readdata = {30'b0, irq, busy};
         default: avs_readdata = key[avs_address[3:2]];
      endcase
   end

   // One complete XTEA cycle (both Feistel halves) per clock.
   always_comb begin
      v0_n  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + key[sum[1:0]]));
      sum_n = sum + DELTA;
      v1_n  = v1 + ((((v0_n << 4) ^ (v0_n >> 5)) + v0_n) ^ (sum_n + key[sum_n[12:11]]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         src_cnt       <= '0;
         dest_cnt      <= '0;
         rem_cnt       <= '0;
         v0            <= '0;
         v1            <= '0;
         sum           <= '0;
         round_cnt     <= '0;
         irq           <= 1'b0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl_wr) begin
                  irq <= 1'b0;
                  if (avs_writedata[0]) begin
                     if (num_reg == '0) begin
                        irq <= 1'b1;
                     end else begin
                        src_cnt     <= {src_reg[31:2], 2'b00};
                        dest_cnt    <= {dest_reg[31:2], 2'b00};
                        rem_cnt     <= num_reg;
                        sum         <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= {src_reg[31:2], 2'b00};
                        state       <= RD0;
                     end
                  end
               end
            end
            RD0: if (!avm_waitrequest) begin
               v0          <= avm_readdata;
               avm_address <= src_cnt + 32'd4;
               state       <= RD1;
            end
            RD1: if (!avm_waitrequest) begin
               v1        <= avm_readdata;
               avm_read  <= 1'b0;
               sum       <= '0;
               round_cnt <= '0;
               state     <= CALC;
            end
            CALC: begin
               v0        <= v0_n;
               v1        <= v1_n;
               sum       <= sum_n;
               round_cnt <= round_cnt + 32'd1;
               if (round_cnt == LAST_ROUND) begin
                  avm_write     <= 1'b1;
                  avm_address   <= dest_cnt;
                  avm_writedata <= v0_n;
                  state         <= WR0;
               end
            end
            WR0: if (!avm_waitrequest) begin
               avm_address   <= dest_cnt + 32'd4;
               avm_writedata <= v1;
               state         <= WR1;
            end
            WR1: if (!avm_waitrequest) begin
               avm_write <= 1'b0;
               state     <= NEXT;
            end
            NEXT: begin
               src_cnt  <= src_cnt + 32'd8;
               dest_cnt <= dest_cnt + 32'd8;
               rem_cnt  <= rem_cnt - 32'd1;
               if (rem_cnt == 32'd1) begin
                  irq   <= 1'b1;
                  state <= IDLE;
               end else begin
                  avm_read    <= 1'b1;
                  avm_address <= src_cnt + 32'd8;
                  state       <= RD0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_accel.sv
// Bench for avalon_accel: register map, XTEA jobs against a C-style model with a
// word-addressed memory, random master stalls, zero-length jobs and reset abort.
module tb_avalon_accel;

   localparam logic [31:0] DELTA     = 32'h9E3779B9;
   localparam int          ROUNDS    = 32;
   localparam int          MEM_WORDS = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        irq;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] mdl_mem [MEM_WORDS];
   logic [31:0] save_mem[MEM_WORDS];
   logic [31:0] key_m   [4];
   logic [31:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   logic stall_en = 1'b0;
   int stall_err = 0, both_err = 0, align_err = 0, bus_cycles = 0;

   logic        prev_hold = 1'b0;
   logic        prev_rd, prev_wr;
   logic [31:0] prev_addr, prev_wd;

   avalon_accel #(.DELTA(DELTA), .ROUNDS(ROUNDS)) dut (
      .clk             (clk),
      .reset           (reset),
      .avs_address     (avs_address),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .irq             (irq)
   );

   // ---------------- clock ----------------
   always #10 clk = ~clk;

   // ---------------- memory slave ----------------
   assign avm_readdata = mem[avm_address[11:2]];

   initial begin
      avm_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         avm_waitrequest = stall_en && ($urandom_range(0, 99) < 40);
      end
   end

   // Bus monitor and write port, sampled mid-cycle.
   always @(negedge clk) begin
      if (avm_read || avm_write) bus_cycles++;
      if (avm_read && avm_write) both_err++;
      if ((avm_read || avm_write) && avm_address[1:0] != 2'b00) align_err++;
      if (prev_hold && !reset &&
          (avm_read != prev_rd || avm_write != prev_wr || avm_address != prev_addr ||
           (prev_wr && avm_writedata != prev_wd)))
         stall_err++;
      prev_hold = (avm_read || avm_write) && avm_waitrequest && !reset;
      prev_rd   = avm_read;
      prev_wr   = avm_write;
      prev_addr = avm_address;
      prev_wd   = avm_writedata;
      if (avm_write && !avm_waitrequest && !reset) mem[avm_address[11:2]] = avm_writedata;
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic avs_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic avs_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      #1;
      d = avs_readdata;
   endtask

   task automatic wait_irq(input int budget, output int cycles);
      cycles = 0;
      while (!irq && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check_eq("irq_raised", {31'b0, irq}, 32'd1);
   endtask

   // ---------------- reference model ----------------
   function automatic int wi(input logic [31:0] a);
      return int'(a[11:2]);
   endfunction

   function automatic logic [63:0] xtea_enc(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < ROUNDS; i++) begin
         a = a + ((((b << 4) ^ (b >> 5)) + b) ^ (s + key_m[s & 32'd3]));
         s = s + DELTA;
         b = b + ((((a << 4) ^ (a >> 5)) + a) ^ (s + key_m[(s >> 11) & 32'd3]));
      end
      return {a, b};
   endfunction

   task automatic run_job(input logic [31:0] k0, k1, k2, k3, src, dest, num,
                          input int budget, input bit poke, input string tag,
                          output int cycles);
      logic [31:0] rd, sa, da;
      logic [63:0] r;
      avs_wr(5'h00, k0);
      avs_wr(5'h04, k1);
      avs_wr(5'h08, k2);
      avs_wr(5'h0C, k3);
      avs_wr(5'h10, src);
      avs_wr(5'h14, dest);
      avs_wr(5'h18, num);
      key_m[0] = k0; key_m[1] = k1; key_m[2] = k2; key_m[3] = k3;
      for (int i = 0; i < MEM_WORDS; i++) mdl_mem[i] = mem[i];
      exp_q.delete();
      for (int b = 0; b < int'(num); b++) begin
         sa = src + 32'(8 * b);
         da = dest + 32'(8 * b);
         r = xtea_enc(mdl_mem[wi(sa)], mdl_mem[wi(sa + 32'd4)]);
         mdl_mem[wi(da)]          = r[63:32];
         mdl_mem[wi(da + 32'd4)]  = r[31:0];
         exp_q.push_back(r[63:32]);
         exp_q.push_back(r[31:0]);
      end
      avs_wr(5'h1C, 32'd1);
      if (poke) begin
         avs_rd(5'h1C, rd);
         check_eq("ctrl_busy", rd, 32'd1);
         avs_wr(5'h00, ~k0);
         avs_wr(5'h18, num + 32'd5);
         avs_wr(5'h1C, 32'd1);
      end
      wait_irq(budget, cycles);
      for (int i = 0; i < 2 * int'(num); i++) begin
         da = dest + 32'(4 * i);
         check_eq(tag, mem[wi(da)], exp_q.pop_front());
      end
      if (poke) begin
         avs_rd(5'h00, rd);
         check_eq("k0_busy_ignored", rd, k0);
         avs_rd(5'h18, rd);
         check_eq("num_busy_ignored", rd, num);
      end
      avs_wr(5'h1C, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] rd;
      logic [31:0] pat [8];
      int cyc, bus0;

      avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      do_reset();

      // reset state
      for (int a = 0; a < 8; a++) begin
         avs_rd(5'(a * 4), rd);
         check_eq("reset_reg", rd, 32'd0);
      end
      check_eq("reset_irq",   {31'b0, irq}, 32'd0);
      check_eq("reset_rdwr",  {30'b0, avm_read, avm_write}, 32'd0);
      check_eq("reset_maddr", avm_address, 32'd0);
      check_eq("reset_mwd",   avm_writedata, 32'd0);

      // register readback
      for (int a = 0; a < 7; a++) pat[a] = $urandom();
      pat[4] = pat[4] & 32'hFFFF_FFFC;
      pat[5] = pat[5] & 32'hFFFF_FFFC;
      for (int a = 0; a < 7; a++) avs_wr(5'(a * 4), pat[a]);
      avs_wr(5'h1C, 32'd0);
      for (int a = 0; a < 7; a++) begin
         avs_rd(5'(a * 4), rd);
         check_eq("reg_readback", rd, pat[a]);
      end
      avs_rd(5'h1C, rd);
      check_eq("ctrl_idle", rd, 32'd0);

      // known-answer block with zero key
      mem[0] = 32'd0; mem[1] = 32'd0;
      run_job(0, 0, 0, 0, 32'h000, 32'h100, 32'd1, 50, 1'b0, "kat_model", cyc);
      check_eq("kat_v0", mem[32'h40], 32'hdee9d4d8);
      check_eq("kat_v1", mem[32'h41], 32'hf7131ed9);
      check_eq("kat_latency_ok", {31'b0, cyc <= 50}, 32'd1);

      // 64-block job, no stalls, with writes attempted while busy
      for (int i = 32'h80; i < 32'h100; i++) mem[i] = $urandom();
      for (int i = 0; i < MEM_WORDS; i++) save_mem[i] = mem[i];
      run_job(32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233,
              32'h200, 32'h100, 32'h40, 3200, 1'b1, "job64", cyc);
      avs_rd(5'h10, rd); check_eq("src_unchanged",  rd, 32'h200);
      avs_rd(5'h14, rd); check_eq("dest_unchanged", rd, 32'h100);
      avs_rd(5'h18, rd); check_eq("num_unchanged",  rd, 32'h40);

      // same job with random stalls
      for (int i = 32'h40; i < 32'hC0; i++) mem[i] = 32'd0;
      for (int i = 32'h80; i < 32'h100; i++) mem[i] = save_mem[i];
      stall_en = 1'b1;
      run_job(32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233,
              32'h200, 32'h100, 32'h40, 20000, 1'b0, "job64_stall", cyc);
      stall_en = 1'b0;

      // zero-length job
      bus0 = bus_cycles;
      avs_wr(5'h18, 32'd0);
      avs_wr(5'h1C, 32'd1);
      wait_irq(2, cyc);
      check_eq("num0_no_bus", 32'(bus_cycles - bus0), 32'd0);
      avs_rd(5'h1C, rd);
      check_eq("ctrl_irq", rd, 32'd2);
      avs_wr(5'h1C, 32'd0);
      check_eq("irq_ack", {31'b0, irq}, 32'd0);

      // reset in the middle of CALC
      avs_wr(5'h18, 32'd2);
      avs_wr(5'h1C, 32'd1);
      repeat (10) @(negedge clk);
      avs_rd(5'h1C, rd);
      check_eq("midjob_busy", rd, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("abort_irq",  {31'b0, irq}, 32'd0);
      check_eq("abort_rdwr", {30'b0, avm_read, avm_write}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      avs_rd(5'h1C, rd); check_eq("abort_ctrl", rd, 32'd0);
      avs_rd(5'h00, rd); check_eq("abort_k0",   rd, 32'd0);

      // random jobs, including an address wrap and stalls
      for (int i = 32'h100; i < 32'h200; i++) mem[i] = $urandom();
      run_job($urandom(), $urandom(), $urandom(), $urandom(),
              32'h400, 32'hA00, 32'(5), 2000, 1'b0, "rand_job", cyc);
      stall_en = 1'b1;
      run_job($urandom(), $urandom(), $urandom(), $urandom(),
              32'h408 + 32'(8 * $urandom_range(0, 60)), 32'hB00, 32'($urandom_range(1, 6)),
              5000, 1'b0, "rand_job_stall", cyc);
      run_job($urandom(), $urandom(), $urandom(), $urandom(),
              32'hFFFF_FFF0, 32'h900, 32'd4, 5000, 1'b0, "wrap_job", cyc);
      stall_en = 1'b0;

      check_eq("stall_stable", 32'(stall_err), 32'd0);
      check_eq("rd_wr_exclusive", 32'(both_err), 32'd0);
      check_eq("addr_aligned", 32'(align_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
